// File: rtl/clock_pkg.sv
// clock_pkg: shared constants for the clock/timer counter family.
// Provides the standard moduli for seconds, minutes, hours and centiseconds.
// Also provides the BCD digit width and an elaboration-time width helper.
package clock_pkg;

  localparam int MOD_SEC   = 60;
  localparam int MOD_MIN   = 60;
  localparam int MOD_HOUR  = 24;
  localparam int MOD_CENTI = 100;
  localparam int BCD_W     = 4;

  // Largest value a counter of the given width can hold.
  function automatic int max_for_width(input int width);
    return (2 ** width) - 1;
  endfunction

endpackage

// File: rtl/mod_counter_bin2bcd.sv
// mod_counter_bin2bcd: combinational binary (0..99) to two BCD digits.
// The tens digit is found by comparing against multiples of ten.
// The units digit is the remainder after removing tens*10.
module mod_counter_bin2bcd
  import clock_pkg::*;
#(
  parameter int WIDTH = 7
) (
  input  logic [WIDTH-1:0] bin,
  output logic [BCD_W-1:0] tens,
  output logic [BCD_W-1:0] units
);

  int bin_i;
  int tens_i;

  // Pick the largest multiple of ten not exceeding the input, then take the remainder.
  always_comb begin
    bin_i  = int'(bin);
    tens_i = 0;
    for (int t = 1; t < 10; t++) begin
      if (bin_i >= t * 10) tens_i = t;
    end
    tens  = BCD_W'(tens_i);
    units = BCD_W'(bin_i - tens_i * 10);
  end

endmodule

// File: rtl/mod_counter.sv
// mod_counter: modulo-N counter with preset, BCD outputs and wrap pulses.
// Optional feature macro: MOD_COUNTER_DOWN_EN adds the 'up' direction port
// and down counting with borrow_out; without it the counter only counts up
// and borrow_out is tied low.
// Priority each cycle: rst, then load, then en, then hold. carry_out,
// borrow_out and load_err are single-cycle pulses aligned with the cnt
// update they describe, so carry_out can drive the en of the next stage.
module mod_counter
  import clock_pkg::*;
#(
  parameter int MODULUS = MOD_SEC,
  parameter int WIDTH   = 7
) (
  input  logic             clk100hz,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
`ifdef MOD_COUNTER_DOWN_EN
  input  logic             up,
`endif
  output logic [WIDTH-1:0] cnt,
  output logic [BCD_W-1:0] bcd_tens,
  output logic [BCD_W-1:0] bcd_units,
  output logic             carry_out,
  output logic             borrow_out,
  output logic             load_err
);

  // Reject illegal configurations at elaboration.
  if (MODULUS < 2 || MODULUS > 100) begin : g_bad_modulus
    $error("mod_counter: MODULUS must be in 2..100");
  end
  if (max_for_width(WIDTH) < MODULUS - 1) begin : g_bad_width
    $error("mod_counter: WIDTH too small for MODULUS");
  end

  localparam logic [WIDTH-1:0] MAX_CNT = WIDTH'(MODULUS - 1);

  logic             dir_up;
  logic [WIDTH-1:0] cnt_nxt;
  logic             carry_nxt;
  logic             borrow_nxt;
  logic             lerr_nxt;
  logic [BCD_W-1:0] tens_nxt;
  logic [BCD_W-1:0] units_nxt;

`ifdef MOD_COUNTER_DOWN_EN
  assign dir_up = up;
`else
  assign dir_up = 1'b1;
`endif

  // Next-count logic: load wins over en; wrap pulses only on counting steps.
  always_comb begin
    cnt_nxt    = cnt;
    carry_nxt  = 1'b0;
    borrow_nxt = 1'b0;
    lerr_nxt   = 1'b0;
    if (load) begin
      if (load_val <= MAX_CNT) cnt_nxt = load_val;
      else                     lerr_nxt = 1'b1;
    end else if (en) begin
      if (dir_up) begin
        if (cnt >= MAX_CNT) begin
          cnt_nxt   = '0;
          carry_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt + WIDTH'(1);
        end
      end else begin
        if (cnt == '0) begin
          cnt_nxt    = MAX_CNT;
          borrow_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt - WIDTH'(1);
        end
      end
    end
  end

  // BCD digits are derived from the next count so they register alongside cnt.
  mod_counter_bin2bcd #(.WIDTH(WIDTH)) u_bin2bcd (
    .bin   (cnt_nxt),
    .tens  (tens_nxt),
    .units (units_nxt)
  );

  // State register: synchronous reset clears count, digits and all pulses.
  always_ff @(posedge clk100hz) begin
    if (rst) begin
      cnt        <= '0;
      bcd_tens   <= '0;
      bcd_units  <= '0;
      carry_out  <= 1'b0;
      borrow_out <= 1'b0;
      load_err   <= 1'b0;
    end else begin
      cnt        <= cnt_nxt;
      bcd_tens   <= tens_nxt;
      bcd_units  <= units_nxt;
      carry_out  <= carry_nxt;
`ifdef MOD_COUNTER_DOWN_EN
      borrow_out <= borrow_nxt;
`else
      borrow_out <= 1'b0;
`endif
      load_err   <= lerr_nxt;
    end
  end

`ifndef MOD_COUNTER_DOWN_EN
  logic unused_borrow;
  assign unused_borrow = borrow_nxt;
`endif

endmodule

// File: tb/tb_mod_counter.sv
// tb_mod_counter: scoreboard bench for mod_counter (MODULUS 60 and 24).
// Both instances share stimulus; a reference model pushes the expected
// {cnt, tens, units, carry, borrow, load_err} word per instance each cycle.
module tb_mod_counter;

  localparam int W = 18;

  logic       clk100hz;
  logic       rst;
  logic       en;
  logic       load;
  logic [6:0] load_val;
  logic       up;

  logic [6:0] cnt60, cnt24;
  logic [3:0] tens60, units60, tens24, units24;
  logic       carry60, borrow60, lerr60, carry24, borrow24, lerr24;

  logic [W-1:0] exp60_q[$];
  logic [W-1:0] exp24_q[$];

  int n_vec;
  int n_err;
  int m60;
  int m24;

  mod_counter #(.MODULUS(60), .WIDTH(7)) dut60 (
    .clk100hz   (clk100hz),
    .rst        (rst),
    .en         (en),
    .load       (load),
    .load_val   (load_val),
`ifdef MOD_COUNTER_DOWN_EN
    .up         (up),
`endif
    .cnt        (cnt60),
    .bcd_tens   (tens60),
    .bcd_units  (units60),
    .carry_out  (carry60),
    .borrow_out (borrow60),
    .load_err   (lerr60)
  );

  mod_counter #(.MODULUS(24), .WIDTH(7)) dut24 (
    .clk100hz   (clk100hz),
    .rst        (rst),
    .en         (en),
    .load       (load),
    .load_val   (load_val),
`ifdef MOD_COUNTER_DOWN_EN
    .up         (up),
`endif
    .cnt        (cnt24),
    .bcd_tens   (tens24),
    .bcd_units  (units24),
    .carry_out  (carry24),
    .borrow_out (borrow24),
    .load_err   (lerr24)
  );

  // Clock and initial input levels.
  initial begin
    clk100hz = 1'b0;
    forever #5 clk100hz = ~clk100hz;
  end

  initial begin
    rst = 1'b1; en = 1'b0; load = 1'b0; load_val = '0; up = 1'b1;
  end

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got cnt=%0d tens=%0d units=%0d c=%0b b=%0b e=%0b exp cnt=%0d tens=%0d units=%0d c=%0b b=%0b e=%0b",
               tag, got[17:11], got[10:7], got[6:3], got[2], got[1], got[0],
               exp[17:11], exp[10:7], exp[6:3], exp[2], exp[1], exp[0]);
    end
  endtask

  function automatic logic [W-1:0] pack(input int c, input bit ca, input bit bo, input bit le);
    return {7'(c), 4'(c / 10), 4'(c % 10), ca, bo, le};
  endfunction

  // Reference behaviour of one counter for one clock edge.
  function automatic logic [W-1:0] model(input int m, inout int c, input bit r, input bit l,
                                         input int lv, input bit e, input bit u);
    bit ca, bo, le, ue;
    ca = 0; bo = 0; le = 0;
`ifdef MOD_COUNTER_DOWN_EN
    ue = u;
`else
    ue = 1;
`endif
    if (r) c = 0;
    else if (l) begin
      if (lv < m) c = lv;
      else le = 1;
    end else if (e) begin
      if (ue) begin
        if (c == m - 1) begin c = 0; ca = 1; end
        else c = c + 1;
      end else begin
        if (c == 0) begin c = m - 1; bo = 1; end
        else c = c - 1;
      end
    end
    return pack(c, ca, bo, le);
  endfunction

  // Drive one cycle, push expectations, then compare after the edge.
  task automatic step(input string tag, input bit r, input bit l, input int lv,
                      input bit e, input bit u);
    logic [W-1:0] e60, e24;
    @(negedge clk100hz);
    rst = r; load = l; load_val = 7'(lv); en = e; up = u;
    exp60_q.push_back(model(60, m60, r, l, lv, e, u));
    exp24_q.push_back(model(24, m24, r, l, lv, e, u));
    @(posedge clk100hz);
    #1;
    if (exp60_q.size() == 0 || exp24_q.size() == 0) begin
      n_vec++; n_err++;
      $display("FAIL %s scoreboard empty", tag);
    end else begin
      e60 = exp60_q.pop_front();
      e24 = exp24_q.pop_front();
      check({tag, "/m60"}, {cnt60, tens60, units60, carry60, borrow60, lerr60}, e60);
      check({tag, "/m24"}, {cnt24, tens24, units24, carry24, borrow24, lerr24}, e24);
    end
  endtask

  initial begin
    n_vec = 0; n_err = 0; m60 = 0; m24 = 0;

    step("reset", 1, 0, 0, 0, 1);
    step("reset", 1, 1, 5, 1, 1);

    // Wrap at 59 -> 0 with a single carry pulse.
    step("load58", 0, 1, 58, 0, 1);
    step("wrap59", 0, 0, 0, 1, 1);
    step("wrap0", 0, 0, 0, 1, 1);
    step("wrap1", 0, 0, 0, 1, 1);

    // Load 23 then wrap the modulus-24 counter.
    step("load23", 0, 1, 23, 0, 1);
    step("en23", 0, 0, 0, 1, 1);
    step("idle", 0, 0, 0, 0, 1);

    // Out-of-range preset leaves the count alone.
    step("load12", 0, 1, 12, 0, 1);
    step("badload", 0, 1, 75, 0, 1);
    step("badafter", 0, 0, 0, 0, 1);

    // Reset wins over load and en, and kills a pending wrap.
    step("load45", 0, 1, 45, 0, 1);
    step("rstprio", 1, 1, 30, 1, 1);
    step("load59", 0, 1, 59, 0, 1);
    step("rstwrap", 1, 0, 0, 1, 1);

    // Hold for ten cycles at 7.
    step("load7", 0, 1, 7, 0, 1);
    for (int i = 0; i < 10; i++) step("hold", 0, 0, 0, 0, 1);

    // Load takes precedence over en in the same cycle.
    step("loaden", 0, 1, 5, 1, 1);
    step("loaden2", 0, 1, 99, 1, 1);

`ifdef MOD_COUNTER_DOWN_EN
    step("load0", 0, 1, 0, 0, 0);
    step("borrow", 0, 0, 0, 1, 0);
    step("down", 0, 0, 0, 1, 0);
`endif

    // Random mixed traffic.
    for (int i = 0; i < 400; i++) begin
      bit r, l, e, u;
      int lv;
      r  = ($urandom_range(0, 39) == 0);
      l  = ($urandom_range(0, 7) == 0);
      lv = $urandom_range(0, 110);
      e  = ($urandom_range(0, 3) != 0);
      u  = 1'($urandom_range(0, 1));
      step("rand", r, l, lv, e, u);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
